// File: rtl/heartbeat_pkg.sv
// Shared LED mode encodings for the heartbeat LED generator and its channels.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

endpackage : heartbeat_pkg

// File: rtl/heartbeat_led_ch.sv
// One LED channel: selects off/on/blink/breathe from the shared sources,
// applies output polarity and registers the drive (1-cycle latency, no backpressure).
module heartbeat_led_ch
  import heartbeat_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  mode_t i_mode,
  input  logic  i_blink,
  input  logic  i_breathe,
  output logic  o_led
);

  logic w_raw;
  logic r_led;

  always_comb begin
    w_raw = 1'b0;
    unique case (i_mode)
      MODE_OFF:     w_raw = 1'b0;
      MODE_ON:      w_raw = 1'b1;
      MODE_BLINK:   w_raw = i_blink;
      MODE_BREATHE: w_raw = i_breathe;
      default:      w_raw = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= ACTIVE_LOW;
    end else begin
      r_led <= w_raw ^ ACTIVE_LOW;
    end
  end

  assign o_led = r_led;

endmodule : heartbeat_led_ch

// File: rtl/heartbeat_led_gen.sv
// Multi-channel heartbeat: shared heartbeat/PWM counters feed CHANNELS LED drivers.
// Breathe (triangle PWM) mode is built only with HEARTBEAT_BREATHE_EN; otherwise mode 11 blinks.
module heartbeat_led_gen
  import heartbeat_pkg::*;
#(
  parameter int unsigned CHANNELS   = 5,
  parameter int unsigned WIDTH      = 22,
  parameter int unsigned PWM_W      = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_n,
  input  logic                  sync_clr,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led_out,
  output logic                  data_out_msb,
  output logic                  tick
);

  logic [WIDTH-1:0] r_hb_cnt;
  logic             r_tick;
  logic             w_wrap;
  logic             w_blink;
  logic             w_breathe;

  assign w_wrap  = &r_hb_cnt;
  assign w_blink = r_hb_cnt[WIDTH-1];

  // Clear beats counting, so a clear coinciding with a wrap never raises tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hb_cnt <= '0;
      r_tick   <= 1'b0;
    end else if (sync_clr) begin
      r_hb_cnt <= '0;
      r_tick   <= 1'b0;
    end else if (!enable_n) begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
      r_tick   <= w_wrap;
    end else begin
      r_tick   <= 1'b0;
    end
  end

`ifdef HEARTBEAT_BREATHE_EN
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W:0]   w_phase;
  logic [PWM_W-1:0] w_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (sync_clr) begin
      r_pwm_cnt <= '0;
    end else if (!enable_n) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Top bits of the heartbeat fold into a 0 -> max -> 0 brightness ramp.
  assign w_phase   = r_hb_cnt[WIDTH-1 -: PWM_W+1];
  assign w_level   = w_phase[PWM_W] ? ~w_phase[PWM_W-1:0] : w_phase[PWM_W-1:0];
  assign w_breathe = (r_pwm_cnt < w_level);
`else
  localparam int unsigned PWM_W_UNUSED = PWM_W;
  assign w_breathe = w_blink;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    heartbeat_led_ch #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (reset_n),
      .i_mode    (mode_t'(mode[2*gi +: 2])),
      .i_blink   (w_blink),
      .i_breathe (w_breathe),
      .o_led     (led_out[gi])
    );
  end

  assign data_out_msb = r_hb_cnt[WIDTH-1];
  assign tick         = r_tick;

endmodule : heartbeat_led_gen
